// File: rtl/medidor_pkg.sv
// Shared types and defaults for the frequency meter.
// The optional glitch filter is enabled by defining MEDIDOR_FILTRO_EN.
package medidor_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      LATCH = 2'd2
   } estado_t;

   localparam int unsigned GATE_CYCLES_DEF = 100000000;
   localparam int unsigned CNT_W_DEF       = 26;

   // Bits needed to hold ciclos-1, at least one bit.
   function automatic int unsigned ancho_gate(input int unsigned ciclos);
      return (ciclos > 1) ? $clog2(ciclos) : 1;
   endfunction

   localparam int unsigned GATE_W = ancho_gate(GATE_CYCLES_DEF);

endpackage

// File: rtl/sincronizador_flanco.sv
// 2-flop synchronizer, optional glitch filter (MEDIDOR_FILTRO_EN) and registered
// rising-edge detector. Latency from d_async rise to edge_o is 3 cycles (+FILTER_CYCLES).
module sincronizador_flanco import medidor_pkg::*; #(
   parameter int unsigned FILTER_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic d_async,
   output logic edge_o
);

   logic sinc1_q, sinc2_q;
   logic nivel;
   logic nivel_prev_q, edge_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sinc1_q <= 1'b0;
         sinc2_q <= 1'b0;
      end else begin
         sinc1_q <= d_async;
         sinc2_q <= sinc1_q;
      end
   end

`ifdef MEDIDOR_FILTRO_EN
   localparam int unsigned FiltW = ancho_gate(FILTER_CYCLES);
   localparam logic [FiltW-1:0] FiltLast = FiltW'(FILTER_CYCLES - 1);

   logic [FiltW-1:0] filt_cnt_q;
   logic             filt_q;

   // The filtered level follows only after FILTER_CYCLES consecutive differing samples.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         filt_cnt_q <= '0;
         filt_q     <= 1'b0;
      end else if (sinc2_q == filt_q) begin
         filt_cnt_q <= '0;
      end else if (filt_cnt_q == FiltLast) begin
         filt_q     <= sinc2_q;
         filt_cnt_q <= '0;
      end else begin
         filt_cnt_q <= filt_cnt_q + 1'b1;
      end
   end

   assign nivel = filt_q;
`else
   logic unused_filtro;
   assign unused_filtro = ^FILTER_CYCLES;
   assign nivel = sinc2_q;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         nivel_prev_q <= 1'b0;
         edge_q       <= 1'b0;
      end else begin
         nivel_prev_q <= nivel;
         edge_q       <= nivel & ~nivel_prev_q;
      end
   end

   assign edge_o = edge_q;

endmodule

// File: rtl/medidor_frecuencia.sv
// Frequency meter: counts sig_in rising edges over a GATE_CYCLES window after start.
// Define MEDIDOR_FILTRO_EN to insert the glitch filter in the input path.
module medidor_frecuencia import medidor_pkg::*; #(
   parameter int unsigned GATE_CYCLES   = GATE_CYCLES_DEF,
   parameter int unsigned CNT_W         = CNT_W_DEF,
   parameter int unsigned FILTER_CYCLES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sig_in,
   input  logic             start,
   output logic             busy,
   output logic [CNT_W-1:0] freq_hz,
   output logic             valid,
   output logic             overflow
);

   localparam int unsigned      GateW    = ancho_gate(GATE_CYCLES);
   localparam logic [GateW-1:0] GateLast = GateW'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CntMax   = '1;

   estado_t          estado_q;
   logic [GateW-1:0] gate_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sat_q, sat_d;
   logic             edge_pulso;

   sincronizador_flanco #(
      .FILTER_CYCLES(FILTER_CYCLES)
   ) u_sincronizador_flanco (
      .clk    (clk),
      .reset  (reset),
      .d_async(sig_in),
      .edge_o (edge_pulso)
   );

   // Saturating edge count including this cycle's edge, so the last gate cycle is counted.
   always_comb begin
      cnt_d = cnt_q;
      sat_d = sat_q;
      if (edge_pulso) begin
         if (cnt_q == CntMax) begin
            sat_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado_q <= IDLE;
         gate_q   <= '0;
         cnt_q    <= '0;
         sat_q    <= 1'b0;
         busy     <= 1'b0;
         freq_hz  <= '0;
         valid    <= 1'b0;
         overflow <= 1'b0;
      end else begin
         valid <= 1'b0;
         unique case (estado_q)
            IDLE: begin
               if (start) begin
                  estado_q <= COUNT;
                  gate_q   <= '0;
                  cnt_q    <= '0;
                  sat_q    <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            COUNT: begin
               cnt_q  <= cnt_d;
               sat_q  <= sat_d;
               gate_q <= gate_q + 1'b1;
               if (gate_q == GateLast) begin
                  estado_q <= LATCH;
                  freq_hz  <= cnt_d;
                  overflow <= sat_d;
                  valid    <= 1'b1;
               end
            end
            LATCH: begin
               estado_q <= IDLE;
               busy     <= 1'b0;
            end
            default: estado_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_medidor_frecuencia.sv
// Self-checking bench for medidor_frecuencia with a scoreboard of expected valid results.
// Expectations adapt when MEDIDOR_FILTRO_EN is defined.
module tb_medidor_frecuencia;

   localparam int unsigned G = 1000;
   localparam int unsigned W = 8;
   localparam int unsigned F = 4;

`ifdef MEDIDOR_FILTRO_EN
   localparam int Lat       = 3 + F;
   localparam int GlitchExp = 5;
   localparam int SatFreq   = 0;
   localparam int SatOvf    = 0;
`else
   localparam int Lat       = 3;
   localparam int GlitchExp = 25;
   localparam int SatFreq   = 255;
   localparam int SatOvf    = 1;
`endif

   localparam int MNominal    = 0;
   localparam int MSat        = 1;
   localparam int MBajo       = 2;
   localparam int MBusy       = 3;
   localparam int MBordeIn    = 4;
   localparam int MBordeLatch = 5;
   localparam int MGlitch     = 6;

   logic         clk = 1'b0;
   logic         reset;
   logic         sig_in;
   logic         start;
   logic         busy;
   logic [W-1:0] freq_hz;
   logic         valid;
   logic         overflow;

   typedef struct {
      int          freq;
      int          ovf;
      int unsigned ciclo;
   } esperado_t;

   esperado_t   cola[$];
   int          n_checks = 0;
   int          n_fallos = 0;
   int unsigned cyc = 0;

   medidor_frecuencia #(
      .GATE_CYCLES  (G),
      .CNT_W        (W),
      .FILTER_CYCLES(F)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .sig_in  (sig_in),
      .start   (start),
      .busy    (busy),
      .freq_hz (freq_hz),
      .valid   (valid),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fallos++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Scoreboard consumer: every valid pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      if (valid !== 1'b0) begin
         if (cola.size() == 0) begin
            check("valid_inesperado", 32'(valid), 32'd0);
         end else begin
            esperado_t e;
            e = cola.pop_front();
            check("freq_hz", 32'(freq_hz), 32'(e.freq));
            check("overflow", 32'(overflow), 32'(e.ovf));
            check("ciclo_valid", cyc, e.ciclo);
         end
      end
   end

   function automatic logic onda(input int modo, input int t);
      case (modo)
         MNominal, MBusy: return ((t + 50) % 100) < 50;
         MSat:            return (t % 2) == 1;
         MBordeIn:        return t >= (int'(G) - Lat);
         MBordeLatch:     return t >= (int'(G) + 1 - Lat);
         // Clean 200-cycle wave XOR 3-cycle glitches every 50 cycles, away from clean edges.
         MGlitch:         return (t < int'(G)) &&
                                 ((((t + 150) % 200) < 100) ^ ((t % 50) >= 25 && (t % 50) <= 27));
         default:         return 1'b0;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pausa(input int n);
      sig_in = 1'b0;
      start  = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic medir(input int modo, input int exp_freq, input int exp_ovf);
      cola.push_back('{freq: exp_freq, ovf: exp_ovf, ciclo: cyc + G + 1});
      for (int t = 0; t <= int'(G) + 2; t++) begin
         sig_in = onda(modo, t);
         start  = (t == 0) || (modo == MBusy && (t == 10 || t == int'(G) + 1));
         if (t == 0)              check("busy_antes", 32'(busy), 32'd0);
         if (t == 1)              check("busy_sube", 32'(busy), 32'd1);
         if (t == int'(G) + 1)    check("busy_latch", 32'(busy), 32'd1);
         if (t == int'(G) + 2)    check("busy_baja", 32'(busy), 32'd0);
         tick();
      end
      pausa(10);
   endtask

   initial begin
      reset  = 1'b1;
      sig_in = 1'b0;
      start  = 1'b0;
      tick();
      tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_freq", 32'(freq_hz), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      reset = 1'b0;
      pausa(5);

      medir(MNominal, 10, 0);
      medir(MSat, SatFreq, SatOvf);
      medir(MBajo, 0, 0);
      medir(MSat, SatFreq, SatOvf);

      // Abort at gate cycle 500: no valid may follow.
      for (int t = 0; t < 500; t++) begin
         sig_in = onda(MNominal, t);
         start  = (t == 0);
         tick();
      end
      sig_in = onda(MNominal, 500);
      reset  = 1'b1;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_valid", 32'(valid), 32'd0);
      check("abort_freq", 32'(freq_hz), 32'd0);
      check("abort_ovf", 32'(overflow), 32'd0);
      tick();
      tick();
      reset = 1'b0;
      pausa(int'(G) + 20);
      check("abort_sin_valid", cola.size(), 32'd0);

      medir(MNominal, 10, 0);
      medir(MBusy, 10, 0);
      medir(MBordeIn, 1, 0);
      medir(MBordeLatch, 0, 0);
      medir(MGlitch, GlitchExp, 0);

      check("cola_vacia", cola.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fallos);
      $finish;
   end

endmodule
